itch_msg_aligner: RTL

- Generic, parametrised successor to the fixed-layout ITCH per-message parsers.
- Takes a stream of DATA_W-bit beats in which a message starts at an arbitrary byte offset and reassembles one message of run-time length into a flat, zero-padded byte vector.
- Field slicing then becomes pure wiring in downstream per-message decoders.
- Sits between the message-type dispatcher and those decoders. It drives signal_end/tracker_out so the dispatcher can start the next message on the shared beat.

---
 rtl/itch_msg_aligner.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/itch_msg_aligner.sv
// ============================================================================
// itch_msg_aligner: reassembles one byte-offset, variable-length message from
// a beat stream into a flat zero-padded vector. Optional: ITCH_ALIGNER_STATS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module itch_msg_aligner #(
  parameter int DATA_W    = 64,
  parameter int MAX_MSG_B = 64,
  parameter int LEN_W     = 7,
  parameter int OFF_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   start,
  input  logic [OFF_W-1:0]       tracker_in,
  input  logic [LEN_W-1:0]       msg_len,
  output logic [8*MAX_MSG_B-1:0] msg_data,
  output logic [LEN_W-1:0]       msg_len_out,
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic                   signal_end,
  output logic [OFF_W-1:0]       tracker_out,
`ifdef ITCH_ALIGNER_STATS_EN
  output logic [31:0]            msg_cnt,
  output logic [15:0]            err_cnt,
`endif
  output logic                   err_len
);

  localparam int BEAT_B = DATA_W / 8;
  localparam int MSG_W  = 8 * MAX_MSG_B;
  localparam int TW     = LEN_W + 1;
  localparam logic [TW-1:0] C_BEAT = TW'(BEAT_B);
  localparam logic [TW-1:0] C_MAX  = TW'(MAX_MSG_B);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] got_q, got_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [MSG_W-1:0] buf_q, buf_d;
  logic [MSG_W-1:0] msg_data_q, msg_data_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic             msg_valid_q, msg_valid_d;
  logic             err_q, err_d;

  logic              accept, is_start, bad_start, len_ok, complete;
  logic [TW-1:0]     ext_len, room, remain, take, base, got_next, byte_idx;
  logic [DATA_W-1:0] src;
  logic [MSG_W-1:0]  placed, assembled;
  logic [OFF_W-1:0]  end_off;

  assign s_ready     = !msg_valid_q || msg_ready;
  assign msg_data    = msg_data_q;
  assign msg_len_out = msg_len_q;
  assign msg_valid   = msg_valid_q;
  assign err_len     = err_q;

  // Datapath: align the beat so its first useful byte lands at message byte
  // 'base', then merge only the bytes this beat contributes.
  always_comb begin
    accept    = s_valid && s_ready;
    ext_len   = {1'b0, msg_len};
    len_ok    = (msg_len != '0) && (ext_len <= C_MAX);
    is_start  = accept && (state_q == IDLE) && start;
    bad_start = is_start && !len_ok;
    room      = C_BEAT - TW'(tracker_in);
    remain    = {1'b0, len_q} - {1'b0, got_q};
    if (state_q == IDLE) begin
      src  = s_data >> {tracker_in, 3'b000};
      base = '0;
      take = (room < ext_len) ? room : ext_len;
    end else begin
      src  = s_data;
      base = {1'b0, got_q};
      take = (C_BEAT < remain) ? C_BEAT : remain;
    end
    got_next  = base + take;
    placed    = MSG_W'(src) << {base, 3'b000};
    assembled = (state_q == COLLECT) ? buf_q : '0;
    byte_idx  = '0;
    for (int i = 0; i < MAX_MSG_B; i++) begin
      byte_idx = TW'(i);
      if (byte_idx >= base && byte_idx < got_next) begin
        assembled[8*i +: 8] = placed[8*i +: 8];
      end
    end
    complete = (is_start && len_ok && (got_next == ext_len)) ||
               (accept && (state_q == COLLECT) && (got_next == {1'b0, len_q}));
  end

  always_comb begin
    state_d     = state_q;
    got_d       = got_q;
    len_d       = len_q;
    off_d       = off_q;
    buf_d       = buf_q;
    msg_data_d  = msg_data_q;
    msg_len_d   = msg_len_q;
    msg_valid_d = msg_valid_q && !msg_ready;
    err_d       = bad_start;
    if (is_start && len_ok) begin
      buf_d   = assembled;
      got_d   = got_next[LEN_W-1:0];
      len_d   = msg_len;
      off_d   = tracker_in;
      state_d = complete ? IDLE : COLLECT;
    end else if (accept && (state_q == COLLECT)) begin
      buf_d = assembled;
      got_d = got_next[LEN_W-1:0];
      if (complete) begin
        state_d = IDLE;
      end
    end
    if (complete) begin
      msg_valid_d = 1'b1;
      msg_data_d  = assembled;
      msg_len_d   = (state_q == IDLE) ? msg_len : len_q;
    end
  end

  // Next message starts where this one ends inside the final beat.
  always_comb begin
    end_off = (state_q == IDLE) ? (tracker_in + msg_len[OFF_W-1:0])
                                : (off_q + len_q[OFF_W-1:0]);
    signal_end  = rst && (bad_start || complete);
    tracker_out = '0;
    if (rst) begin
      if (bad_start) begin
        tracker_out = tracker_in;
      end else if (complete) begin
        tracker_out = end_off;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      got_q       <= '0;
      len_q       <= '0;
      off_q       <= '0;
      buf_q       <= '0;
      msg_data_q  <= '0;
      msg_len_q   <= '0;
      msg_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      got_q       <= got_d;
      len_q       <= len_d;
      off_q       <= off_d;
      buf_q       <= buf_d;
      msg_data_q  <= msg_data_d;
      msg_len_q   <= msg_len_d;
      msg_valid_q <= msg_valid_d;
      err_q       <= err_d;
    end
  end

`ifdef ITCH_ALIGNER_STATS_EN
  logic [31:0] msg_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (complete) begin
        msg_cnt_q <= msg_cnt_q + 32'd1;
      end
      if (bad_start) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign msg_cnt = msg_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire
